// File: rtl/conv_frame_encoder.sv
// conv_frame_encoder
// Convolutional encoder that turns one DATA_FRAME_LENGTH-bit message into a
// stream of packed 16-bit frames. The message is fed MSB first, followed by
// K-1 zero tail bits. Each step emits rate symbols, g0 first.
//
// Ports
//   clk, rst (async, active-low), en (global enable; low freezes everything)
//   i_code_rate   : 0 = rate 1/2, 1 = rate 1/3
//   i_constr_len  : 00/01/10/11 = K 3/5/7/9
//   i_gen_poly    : {g2, g1, g0}, g0 in the low MAX_CONSTRAINT_LENGTH bits;
//                   bit j taps the input delayed j steps (bit 0 = current)
//   i_msg, i_msg_valid / o_msg_ready    : message handshake (IDLE only)
//   o_frame, o_frame_valid / i_frame_ready, o_frame_last : frame handshake
//   o_busy        : FSM is not in IDLE
module conv_frame_encoder #(
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int DATA_FRAME_LENGTH     = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic                                            i_code_rate,
  input  logic [1:0]                                      i_constr_len,
  input  logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0]  i_gen_poly,
  input  logic [DATA_FRAME_LENGTH-1:0]                    i_msg,
  input  logic                                            i_msg_valid,
  output logic                                            o_msg_ready,
  output logic [15:0]                                     o_frame,
  output logic                                            o_frame_valid,
  input  logic                                            i_frame_ready,
  output logic                                            o_frame_last,
  output logic                                            o_busy
);

  localparam int MK  = MAX_CONSTRAINT_LENGTH;
  localparam int DFL = DATA_FRAME_LENGTH;
  localparam int PW  = MAX_CODE_RATE * MK;
  localparam int SW  = $clog2(DFL + MK);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENC       = 2'd1,
    FLUSH     = 2'd2,
    WAIT_LAST = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DFL-1:0]  msg_q, msg_d;       // shifts left; MSB is the current input bit
  logic            rate_q, rate_d;
  logic [1:0]      klen_q, klen_d;
  logic [PW-1:0]   poly_q, poly_d;
  logic [MK-2:0]   sr_q, sr_d;         // sr_q[j-1] = input delayed j steps
  logic [SW-1:0]   step_q, step_d;
  logic [15:0]     pack_q, pack_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     frame_q, frame_d;
  logic            fvalid_q, fvalid_d;
  logic            flast_q, flast_d;
  logic            rdy_q, rdy_d;

  logic [SW-1:0]   k_val_s;
  logic [SW-1:0]   n_steps_s;
  logic [MK-1:0]   mask_s;
  logic [MK-1:0]   window_s;
  logic [2:0]      sym_s;
  logic [3:0]      cap_s;
  logic            full_s;
  logic            out_free_s;
  logic            steps_done_s;
  logic            xfer_s;
  logic            step_s;
  logic [15:0]     base_pack_s;
  logic [3:0]      base_cnt_s;
  logic [4:0]      sh_s;
  logic [15:0]     placed_s;

  // Encoder datapath: window, symbols, pack bookkeeping and handshake qualifiers
  always_comb begin
    k_val_s   = SW'(3'd3) + SW'({klen_q, 1'b0});
    n_steps_s = SW'(DFL) + k_val_s - SW'(1'b1);
    mask_s    = '0;
    for (int j = 0; j < MK; j++) begin
      mask_s[j] = (SW'(j) < k_val_s);
    end
    window_s = {sr_q, msg_q[DFL-1]} & mask_s;
    sym_s    = '0;
    for (int i = 0; i < 3; i++) begin
      sym_s[i] = ^(window_s & poly_q[i*MK +: MK]);
    end
    cap_s        = rate_q ? 4'd5 : 4'd8;
    full_s       = (cnt_q == cap_s);
    out_free_s   = !fvalid_q || i_frame_ready;
    steps_done_s = (step_q == n_steps_s);
    // A full pack moves out when the output register is free; a new symbol may
    // land in the freshly cleared pack on the same edge.
    xfer_s       = full_s && out_free_s;
    step_s       = !steps_done_s && (!full_s || out_free_s);
    base_pack_s  = xfer_s ? 16'h0000 : pack_q;
    base_cnt_s   = xfer_s ? 4'd0 : cnt_q;
    sh_s         = rate_q ? (5'd13 - (5'({1'b0, base_cnt_s}) * 5'd3))
                          : (5'd14 - {base_cnt_s, 1'b0});
    placed_s     = rate_q ? (16'({sym_s[0], sym_s[1], sym_s[2]}) << sh_s)
                          : (16'({sym_s[0], sym_s[1]}) << sh_s);
  end

  // Next-state and register-update logic for the control FSM
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    rate_d   = rate_q;
    klen_d   = klen_q;
    poly_d   = poly_q;
    sr_d     = sr_q;
    step_d   = step_q;
    pack_d   = pack_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    fvalid_d = fvalid_q;
    flast_d  = flast_q;
    rdy_d    = rdy_q;
    if (en) begin
      if (fvalid_q && i_frame_ready) begin
        fvalid_d = 1'b0;
      end else begin
        fvalid_d = fvalid_q;
      end
      case (state_q)
        IDLE: begin
          if (i_msg_valid && rdy_q) begin
            msg_d   = i_msg;
            rate_d  = i_code_rate;
            klen_d  = i_constr_len;
            poly_d  = i_gen_poly;
            sr_d    = '0;
            step_d  = '0;
            pack_d  = 16'h0000;
            cnt_d   = 4'd0;
            state_d = ENC;
          end else begin
            state_d = IDLE;
          end
        end
        ENC: begin
          if (xfer_s) begin
            frame_d  = pack_q;
            fvalid_d = 1'b1;
            flast_d  = steps_done_s;
          end else begin
            frame_d  = frame_q;
          end
          if (step_s) begin
            pack_d = base_pack_s | placed_s;
            cnt_d  = base_cnt_s + 4'd1;
            sr_d   = {sr_q[MK-3:0], msg_q[DFL-1]};
            msg_d  = {msg_q[DFL-2:0], 1'b0};
            step_d = step_q + SW'(1'b1);
          end else begin
            pack_d = base_pack_s;
            cnt_d  = base_cnt_s;
          end
          // An exactly-full final pack leaves from ENC tagged last; a partial
          // one is handed to FLUSH.
          if (xfer_s && steps_done_s) begin
            state_d = WAIT_LAST;
          end else if (step_s && ((step_q + SW'(1'b1)) == n_steps_s) &&
                       ((base_cnt_s + 4'd1) != cap_s)) begin
            state_d = FLUSH;
          end else begin
            state_d = ENC;
          end
        end
        FLUSH: begin
          if (out_free_s) begin
            frame_d  = pack_q;
            fvalid_d = 1'b1;
            flast_d  = 1'b1;
            pack_d   = 16'h0000;
            cnt_d    = 4'd0;
            state_d  = WAIT_LAST;
          end else begin
            state_d  = FLUSH;
          end
        end
        WAIT_LAST: begin
          if (fvalid_q && i_frame_ready) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_LAST;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      rdy_d = (state_d == IDLE);
    end else begin
      rdy_d = rdy_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      rate_q   <= 1'b0;
      klen_q   <= 2'b00;
      poly_q   <= '0;
      sr_q     <= '0;
      step_q   <= '0;
      pack_q   <= 16'h0000;
      cnt_q    <= 4'd0;
      frame_q  <= 16'h0000;
      fvalid_q <= 1'b0;
      flast_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      rate_q   <= rate_d;
      klen_q   <= klen_d;
      poly_q   <= poly_d;
      sr_q     <= sr_d;
      step_q   <= step_d;
      pack_q   <= pack_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      fvalid_q <= fvalid_d;
      flast_q  <= flast_d;
      rdy_q    <= rdy_d;
    end
  end

  assign o_msg_ready   = rdy_q && en;
  assign o_frame       = frame_q;
  assign o_frame_valid = fvalid_q;
  assign o_frame_last  = flast_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench for conv_frame_encoder: directed vector table, hand
// sequences for stall / ignore / reset / enable corners, and randomized
// messages checked against a bit-level reference model.
module tb_conv_frame_encoder;

  localparam int MK  = 9;
  localparam int CR  = 3;
  localparam int DFL = 16;

  logic              clk = 1'b0;
  logic              rst, en, i_code_rate, i_msg_valid, i_frame_ready;
  logic [1:0]        i_constr_len;
  logic [CR*MK-1:0]  i_gen_poly;
  logic [DFL-1:0]    i_msg;
  logic              o_msg_ready, o_frame_valid, o_frame_last, o_busy;
  logic [15:0]       o_frame;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];   // {last, frame}

  always #5 clk = ~clk;

  conv_frame_encoder #(
    .MAX_CONSTRAINT_LENGTH(MK), .MAX_CODE_RATE(CR), .DATA_FRAME_LENGTH(DFL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .i_code_rate(i_code_rate),
    .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_msg(i_msg),
    .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready), .o_frame(o_frame),
    .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
    .o_frame_last(o_frame_last), .o_busy(o_busy)
  );

  typedef struct {
    logic             rate;
    logic [1:0]       kc;
    logic [CR*MK-1:0] poly;
    logic [15:0]      msg;
    int               nfr;
    logic [3:0][15:0] fr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CR*MK-1:0] pk(input logic [8:0] g0, input logic [8:0] g1,
                                          input logic [8:0] g2);
    return {g2, g1, g0};
  endfunction

  // Reference: encode the bit sequence by direct convolution, then chunk symbols into frames.
  function automatic void model(input logic rate, input logic [1:0] kc,
                                input logic [CR*MK-1:0] poly, input logic [15:0] msg);
    int k, n, w, cap, nfr, idx;
    bit u[64];
    bit sy[$];
    bit b;
    logic [15:0] f;
    k   = 3 + 2 * int'(kc);
    n   = DFL + k - 1;
    w   = rate ? 3 : 2;
    cap = rate ? 5 : 8;
    nfr = (n + cap - 1) / cap;
    for (int t = 0; t < 64; t++) u[t] = (t < DFL) ? msg[DFL-1-t] : 1'b0;
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < w; i++) begin
        b = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (s - j >= 0) b = b ^ (poly[i*MK+j] & u[s-j]);
        end
        sy.push_back(b);
      end
    end
    for (int fr = 0; fr < nfr; fr++) begin
      f = 16'h0000;
      for (int sl = 0; sl < cap; sl++) begin
        for (int i = 0; i < w; i++) begin
          idx = (fr * cap + sl) * w + i;
          if (idx < sy.size()) f[15 - sl*w - i] = sy[idx];
        end
      end
      exp_q.push_back({(fr == nfr - 1), f});
    end
  endfunction

  task automatic push_vec(input int v);
    for (int f = 0; f < vecs[v].nfr; f++) exp_q.push_back({(f == vecs[v].nfr - 1), vecs[v].fr[f]});
  endtask

  task automatic send_msg(input logic rate, input logic [1:0] kc,
                          input logic [CR*MK-1:0] poly, input logic [15:0] msg);
    int n;
    en = 1'b1;
    i_code_rate = rate; i_constr_len = kc; i_gen_poly = poly; i_msg = msg;
    i_msg_valid = 1'b1;
    n = 0;
    while (!o_msg_ready && n < 50) begin tick; n++; end
    chk("msg_ready", o_msg_ready, 1);
    tick;
    i_msg_valid = 1'b0;
    // Scramble configuration after capture; it must not matter.
    i_msg = 16'($urandom); i_gen_poly = {$urandom, $urandom};
    i_code_rate = 1'($urandom); i_constr_len = 2'($urandom);
    chk("busy_after_capture", o_busy, 1);
  endtask

  task automatic drain(input int rp, input int ep);
    int cyc;
    logic pv, pacc, pl, acc;
    logic [15:0] pf;
    logic [16:0] e;
    cyc = 0; pv = 1'b0; pacc = 1'b0; pl = 1'b0; pf = 16'h0000;
    while (exp_q.size() > 0 && cyc < 3000) begin
      en            = ($urandom_range(0, 99) < ep);
      i_frame_ready = ($urandom_range(0, 99) < rp);
      if (pv && !pacc) chk("hold", {o_frame_valid, o_frame_last, o_frame}, {1'b1, pl, pf});
      acc = en && o_frame_valid && i_frame_ready;
      if (acc) begin
        e = exp_q.pop_front();
        chk("frame", {o_frame_last, o_frame}, e);
      end
      pv = o_frame_valid; pf = o_frame; pl = o_frame_last; pacc = acc;
      tick;
      cyc++;
    end
    en = 1'b1;
    i_frame_ready = 1'b0;
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_frame_valid, 0);
    chk("idle_ready", o_msg_ready, 1);
  endtask

  initial begin
    logic [19:0] snap;
    int n;
    vecs[0] = '{1'b0, 2'b00, pk(9'h007, 9'h005, 9'h000), 16'h8000, 3, {16'h0000, 16'h0000, 16'h0000, 16'hEC00}};
    vecs[1] = '{1'b1, 2'b00, pk(9'h007, 9'h005, 9'h003), 16'h8000, 4, {16'h0000, 16'h0000, 16'h0000, 16'hF700}};
    vecs[2] = '{1'b0, 2'b11, pk(9'h1FF, 9'h1FF, 9'h000), 16'h8000, 3, {16'h0000, 16'h0000, 16'hC000, 16'hFFFF}};
    vecs[3] = '{1'b0, 2'b00, pk(9'h007, 9'h005, 9'h000), 16'h0001, 3, {16'h0000, 16'hB000, 16'h0003, 16'h0000}};
    vecs[4] = '{1'b1, 2'b01, pk(9'h01F, 9'h011, 9'h001), 16'h8000, 4, {16'h0000, 16'h0000, 16'h0000, 16'hF24C}};

    rst = 1'b0; en = 1'b1; i_code_rate = 1'b0; i_constr_len = 2'b00;
    i_gen_poly = '0; i_msg = '0; i_msg_valid = 1'b0; i_frame_ready = 1'b0;
    tick; tick; tick;
    chk("rst_frame", o_frame, 16'h0000);
    chk("rst_valid", o_frame_valid, 0);
    chk("rst_last", o_frame_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_msg_ready", o_msg_ready, 0);
    rst = 1'b1;
    #2;
    chk("ready_before_edge", o_msg_ready, 0);
    tick;
    chk("ready_after_edge", o_msg_ready, 1);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      push_vec(v);
      send_msg(vecs[v].rate, vecs[v].kc, vecs[v].poly, vecs[v].msg);
      drain(100, 100);
    end

    // Output back-pressure: first frame held for 20 cycles
    exp_q.delete(); push_vec(0);
    i_frame_ready = 1'b0;
    send_msg(vecs[0].rate, vecs[0].kc, vecs[0].poly, vecs[0].msg);
    n = 0;
    while (!o_frame_valid && n < 100) begin tick; n++; end
    chk("stall_valid", o_frame_valid, 1);
    for (int c = 0; c < 20; c++) begin
      chk("stall_hold", {o_frame_valid, o_frame_last, o_frame}, {2'b10, 16'hEC00});
      tick;
    end
    chk("stall_busy", o_busy, 1);
    drain(100, 100);

    // New message offered during ENC is ignored
    exp_q.delete(); push_vec(0);
    send_msg(vecs[0].rate, vecs[0].kc, vecs[0].poly, vecs[0].msg);
    tick; tick;
    i_msg_valid = 1'b1; i_msg = 16'hFFFF; i_constr_len = 2'b11; i_code_rate = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("busy_no_ready", o_msg_ready, 0);
      tick;
    end
    i_msg_valid = 1'b0;
    drain(100, 100);

    // en low for 5 cycles while a frame is pending (ready high must not accept)
    exp_q.delete(); push_vec(0);
    i_frame_ready = 1'b0;
    send_msg(vecs[0].rate, vecs[0].kc, vecs[0].poly, vecs[0].msg);
    n = 0;
    while (!o_frame_valid && n < 100) begin tick; n++; end
    en = 1'b0; i_frame_ready = 1'b1;
    #1;
    snap = {o_frame_valid, o_frame_last, o_busy, o_msg_ready, o_frame};
    chk("en_snapshot", snap, {4'b1010, 16'hEC00});
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("en_freeze", {o_frame_valid, o_frame_last, o_busy, o_msg_ready, o_frame}, snap);
    end
    en = 1'b1;
    drain(100, 100);

    // Reset between first and second frames aborts the message
    exp_q.delete(); push_vec(0);
    i_frame_ready = 1'b1;
    send_msg(vecs[0].rate, vecs[0].kc, vecs[0].poly, vecs[0].msg);
    n = 0;
    while (!o_frame_valid && n < 100) begin tick; n++; end
    chk("rst_mid_first", {o_frame_valid, o_frame}, {1'b1, 16'hEC00});
    tick;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {o_frame_valid, o_frame_last, o_busy, o_msg_ready, o_frame}, 20'h0);
    tick; tick; tick;
    chk("rst_mid_quiet", {o_frame_valid, o_busy}, 2'b00);
    rst = 1'b1;
    tick;
    exp_q.delete(); push_vec(0);
    send_msg(vecs[0].rate, vecs[0].kc, vecs[0].poly, vecs[0].msg);
    drain(100, 100);

    // Randomized messages against the reference model
    for (int r = 0; r < 40; r++) begin
      logic            rr;
      logic [1:0]      kk;
      logic [CR*MK-1:0] pp;
      logic [15:0]     mm;
      rr = 1'($urandom_range(0, 1));
      kk = 2'($urandom_range(0, 3));
      pp = {$urandom, $urandom};
      mm = 16'($urandom);
      exp_q.delete();
      model(rr, kk, pp, mm);
      send_msg(rr, kk, pp, mm);
      drain(70, 85);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
